data_sync_mcp: RTL and testbench
================================

Name: data_sync_mcp

Overview:
Multi-bit clock-domain-crossing receiver for the destination clock domain. A single-bit qualifier, BUS_ENABLE, is passed through a parametrised flop chain. The multi-bit bus UNSYNC_BUS is never synchronised bit-by-bit; it is captured only when a qualifying edge of the synchronised enable is seen (multi-cycle-path formulation). The block adds level/toggle enable modes, a one-cycle ENABLE_PULSE, and sticky overrun detection for events that arrive too close together. It sits between a source-domain register block and destination-domain consumers (e.g. the system controller and the UART TX data path).

Parameters:
- NUM_STAGES, 2: depth of the enable synchroniser chain; legal range 2..4.
- BUS_WIDTH, 8: width of the data bus.
- EN_MODE, 0: 0 = pulse/level mode, an event is a rising edge of the synced enable; 1 = toggle mode, an event is any edge of the synced enable.
- MIN_GAP, 4: minimum number of destination cycles between accepted events before OVERRUN is raised; 0 disables overrun detection.
- RST_VAL, 0: reset value of SYNC_BUS.

Ports:
- CLK  in  1  destination-domain clock.
- RST  in  1  asynchronous reset, active-low.
- UNSYNC_BUS  in  BUS_WIDTH  source-domain data. The source must hold it stable from the enable assertion/toggle until the capture point.
- BUS_ENABLE  in  1  source-domain qualifier; level in mode 0, toggle in mode 1.
- OVR_CLR  in  1  synchronous clear of OVERRUN, destination domain.
- SYNC_BUS  out  BUS_WIDTH  captured data; registered.
- ENABLE_PULSE  out  1  one-cycle strobe marking that SYNC_BUS was updated; registered.
- OVERRUN  out  1  sticky flag: an event arrived fewer than MIN_GAP cycles after the previous one.

Behaviour:
- Reset (RST low, asynchronous):
  - sync chain = 0, edge-detect flop = 0
  - SYNC_BUS = RST_VAL, ENABLE_PULSE = 0, OVERRUN = 0
  - gap counter = MIN_GAP (saturated), so the first event never flags overrun.
- Sync chain: NUM_STAGES flops. en_s is the output of the last stage. en_d is en_s delayed by one flop.
- Event detection (combinational):
  - mode 0: evt = en_s & ~en_d
  - mode 1: evt = en_s ^ en_d
- On a CLK edge with evt = 1: SYNC_BUS <= UNSYNC_BUS and ENABLE_PULSE <= 1. Otherwise SYNC_BUS holds and ENABLE_PULSE <= 0.
- Latency: BUS_ENABLE changes before edge 1 → en_s changes at edge NUM_STAGES → SYNC_BUS and ENABLE_PULSE update at edge NUM_STAGES+1. For NUM_STAGES = 2, that is 3 edges.
- ENABLE_PULSE is exactly one cycle wide per event. In mode 0 a BUS_ENABLE held high gives a single pulse, and a high-low-high sequence gives two pulses once each level has been synchronised.
- Gap counter (width clog2(MIN_GAP+1)):
  - cleared to 0 on evt; otherwise increments, saturating at MIN_GAP.
  - evt while counter < MIN_GAP and MIN_GAP != 0 → OVERRUN <= 1. The data is still captured and the pulse still issued; the latest data wins.
- OVERRUN clear: OVR_CLR = 1 clears OVERRUN, but a simultaneous new overrun takes priority and the flag stays 1.
- Reset release with BUS_ENABLE already high:
  - mode 0: produces one event NUM_STAGES+1 edges later.
  - mode 1: same. The source toggle flop must therefore be reset alongside.
- Reset mid-operation: any in-flight event is discarded, and all outputs return to their reset values immediately (asynchronously).
- Elaboration checks:
  - NUM_STAGES < 2 → fatal.
  - BUS_WIDTH < 1 → fatal.
  - EN_MODE not in {0,1} → fatal.

Decomposition:
- Shared CDC package holds the EN_MODE encodings (EN_MODE_PULSE = 0, EN_MODE_TOGGLE = 1) and a clog2 helper function.
- One natural sub-module, cdc_edge_detect:
  - contains the NUM_STAGES chain, en_d and evt generation, parametrised by NUM_STAGES and EN_MODE.
  - reusable by the pulse synchroniser and the FIFO pointer handshakes.
- Bus capture, pulse register and gap/overrun logic stay in the top module.

Test Plan:
1. Mode 0, NUM_STAGES=2: set UNSYNC_BUS = 0xA5 and raise BUS_ENABLE before edge 1 → SYNC_BUS = 0xA5 and ENABLE_PULSE = 1 after edge 3 only; the pulse is 1 cycle; SYNC_BUS holds 0xA5 while the enable stays high.
2. Mode 1, NUM_STAGES=3: toggle BUS_ENABLE three times, 10 cycles apart, with data 0x11, 0x22, 0x33 → three pulses, each 4 edges after its toggle, SYNC_BUS following each value; OVERRUN = 0.
3. Mode 1, MIN_GAP=4: two toggles 2 cycles apart (data 0x5A then 0xC3) → two pulses, final SYNC_BUS = 0xC3, OVERRUN = 1 from the second pulse onward; OVR_CLR pulse → OVERRUN = 0 the next cycle.
4. OVR_CLR asserted in the same cycle as a new too-close event → OVERRUN remains 1.
5. Assert RST low while an event is inside the chain (1 cycle after a BUS_ENABLE rise) → no pulse ever appears; SYNC_BUS = RST_VAL and OVERRUN = 0 immediately.
6. Mode 0, BUS_ENABLE high and data 0x3C during reset → after RST rises, exactly one pulse with SYNC_BUS = 0x3C at edge NUM_STAGES+1, and no further pulses.

Source files
------------

// File: rtl/data_sync_mcp_pkg.sv
// Shared CDC definitions: enable-mode encodings and a constant clog2 helper.
package data_sync_mcp_pkg;

    localparam int EN_MODE_PULSE  = 0;
    localparam int EN_MODE_TOGGLE = 1;

    function automatic int clog2(input int value);
        int result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/data_sync_mcp_if.sv
// Bus-side signals of the multi-cycle-path receiver: source data/qualifier in, captured data out.
interface data_sync_mcp_if #(parameter int BUS_WIDTH = 8);

    logic [BUS_WIDTH-1:0] UNSYNC_BUS;
    logic                 BUS_ENABLE;
    logic                 OVR_CLR;
    logic [BUS_WIDTH-1:0] SYNC_BUS;
    logic                 ENABLE_PULSE;
    logic                 OVERRUN;

    modport master (
        output UNSYNC_BUS, BUS_ENABLE, OVR_CLR,
        input  SYNC_BUS, ENABLE_PULSE, OVERRUN
    );

    modport slave (
        input  UNSYNC_BUS, BUS_ENABLE, OVR_CLR,
        output SYNC_BUS, ENABLE_PULSE, OVERRUN
    );

endinterface

// File: rtl/data_sync_mcp_cdc_edge_detect.sv
// Synchronises a single-bit qualifier through NUM_STAGES flops and flags a
// rising edge (pulse mode) or any edge (toggle mode) of the synced level.
module cdc_edge_detect
    import data_sync_mcp_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int EN_MODE    = EN_MODE_PULSE
) (
    input  logic CLK,
    input  logic RST,
    input  logic en_async,
    output logic evt
);

    if (NUM_STAGES < 2) begin : g_bad_stages
        $fatal(1, "cdc_edge_detect: NUM_STAGES must be at least 2");
    end
    if (EN_MODE != EN_MODE_PULSE && EN_MODE != EN_MODE_TOGGLE) begin : g_bad_mode
        $fatal(1, "cdc_edge_detect: EN_MODE must be 0 or 1");
    end

    logic [NUM_STAGES-1:0] chain;
    logic                  en_s;
    logic                  en_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            chain <= '0;
            en_d  <= 1'b0;
        end else begin
            chain <= {chain[NUM_STAGES-2:0], en_async};
            en_d  <= en_s;
        end
    end

    assign en_s = chain[NUM_STAGES-1];
    assign evt  = (EN_MODE == EN_MODE_TOGGLE) ? (en_s ^ en_d) : (en_s & ~en_d);

endmodule

// File: rtl/data_sync_mcp.sv
// Destination-side MCP receiver: captures the unsynchronised bus on a synced
// enable event, strobes ENABLE_PULSE and flags events that arrive too close together.
module data_sync_mcp
    import data_sync_mcp_pkg::*;
#(
    parameter int                   NUM_STAGES = 2,
    parameter int                   BUS_WIDTH  = 8,
    parameter int                   EN_MODE    = EN_MODE_PULSE,
    parameter int                   MIN_GAP    = 4,
    parameter logic [BUS_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic CLK,
    input  logic RST,
    data_sync_mcp_if.slave bus
);

    if (BUS_WIDTH < 1) begin : g_bad_width
        $fatal(1, "data_sync_mcp: BUS_WIDTH must be at least 1");
    end

    // Counter must still be one bit wide when overrun detection is disabled.
    localparam int                CNT_W   = (clog2(MIN_GAP + 1) > 0) ? clog2(MIN_GAP + 1) : 1;
    localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(MIN_GAP);

    logic                 evt;
    logic                 too_close;
    logic [CNT_W-1:0]     gap_cnt;
    logic [BUS_WIDTH-1:0] sync_q;
    logic                 pulse_q;
    logic                 ovr_q;

    cdc_edge_detect #(
        .NUM_STAGES (NUM_STAGES),
        .EN_MODE    (EN_MODE)
    ) u_edge (
        .CLK      (CLK),
        .RST      (RST),
        .en_async (bus.BUS_ENABLE),
        .evt      (evt)
    );

    assign too_close = (MIN_GAP != 0) && (gap_cnt < GAP_MAX);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q  <= RST_VAL;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= evt;
            if (evt) sync_q <= bus.UNSYNC_BUS;
        end
    end

    // Counter starts saturated so the first event after reset is never an overrun.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            gap_cnt <= GAP_MAX;
        end else if (evt) begin
            gap_cnt <= '0;
        end else if (gap_cnt != GAP_MAX) begin
            gap_cnt <= gap_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovr_q <= 1'b0;
        end else if (evt && too_close) begin
            ovr_q <= 1'b1;
        end else if (bus.OVR_CLR) begin
            ovr_q <= 1'b0;
        end
    end

    assign bus.SYNC_BUS     = sync_q;
    assign bus.ENABLE_PULSE = pulse_q;
    assign bus.OVERRUN      = ovr_q;

endmodule

// File: tb/tb_data_sync_mcp.sv
// Scoreboard bench: u0 is pulse mode with 2 stages, u1 is toggle mode with 3 stages.
module tb_data_sync_mcp;
    import data_sync_mcp_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    data_sync_mcp_if #(.BUS_WIDTH(8)) if0 ();
    data_sync_mcp_if #(.BUS_WIDTH(8)) if1 ();

    data_sync_mcp #(
        .NUM_STAGES(2), .BUS_WIDTH(8), .EN_MODE(EN_MODE_PULSE), .MIN_GAP(4), .RST_VAL(8'h96)
    ) u0 (.CLK(CLK), .RST(RST), .bus(if0.slave));

    data_sync_mcp #(
        .NUM_STAGES(3), .BUS_WIDTH(8), .EN_MODE(EN_MODE_TOGGLE), .MIN_GAP(4), .RST_VAL(8'hE7)
    ) u1 (.CLK(CLK), .RST(RST), .bus(if1.slave));

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       ovr;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Expected capture edge = drive cycle + NUM_STAGES + 1.
    task automatic push0(input logic [7:0] d, input logic o);
        q0.push_back('{cyc + 3, d, o});
    endtask

    task automatic push1(input logic [7:0] d, input logic o);
        q1.push_back('{cyc + 4, d, o});
    endtask

    task automatic tog1(input logic [7:0] d);
        if1.UNSYNC_BUS = d;
        if1.BUS_ENABLE = ~if1.BUS_ENABLE;
    endtask

    always @(negedge CLK) if (RST) begin
        if (if0.ENABLE_PULSE) begin
            if (q0.size() == 0) chk("u0 unexpected pulse", 32'(if0.ENABLE_PULSE), 0);
            else begin
                e0 = q0.pop_front();
                chk("u0 pulse cycle", cyc, e0.cyc);
                chk("u0 pulse data", 32'(if0.SYNC_BUS), 32'(e0.data));
                chk("u0 pulse overrun", 32'(if0.OVERRUN), 32'(e0.ovr));
            end
        end else if (q0.size() > 0 && q0[0].cyc <= cyc) begin
            chk("u0 missing pulse", 32'(if0.ENABLE_PULSE), 1);
            void'(q0.pop_front());
        end
        if (if1.ENABLE_PULSE) begin
            if (q1.size() == 0) chk("u1 unexpected pulse", 32'(if1.ENABLE_PULSE), 0);
            else begin
                e1 = q1.pop_front();
                chk("u1 pulse cycle", cyc, e1.cyc);
                chk("u1 pulse data", 32'(if1.SYNC_BUS), 32'(e1.data));
                chk("u1 pulse overrun", 32'(if1.OVERRUN), 32'(e1.ovr));
            end
        end else if (q1.size() > 0 && q1[0].cyc <= cyc) begin
            chk("u1 missing pulse", 32'(if1.ENABLE_PULSE), 1);
            void'(q1.pop_front());
        end
    end

    initial begin
        if0.UNSYNC_BUS = 8'h3C; if0.BUS_ENABLE = 1'b1; if0.OVR_CLR = 1'b0;
        if1.UNSYNC_BUS = 8'h00; if1.BUS_ENABLE = 1'b0; if1.OVR_CLR = 1'b0;
        #12;
        chk("u0 reset bus", 32'(if0.SYNC_BUS), 32'h96);
        chk("u0 reset pulse", 32'(if0.ENABLE_PULSE), 0);
        chk("u0 reset overrun", 32'(if0.OVERRUN), 0);
        chk("u1 reset bus", 32'(if1.SYNC_BUS), 32'hE7);
        chk("u1 reset pulse", 32'(if1.ENABLE_PULSE), 0);
        chk("u1 reset overrun", 32'(if1.OVERRUN), 0);

        // Enable already high at reset release: one event, no more.
        tick(1); RST = 1'b1; push0(8'h3C, 1'b0);
        tick(8);
        chk("u0 hold after reset event", 32'(if0.SYNC_BUS), 32'h3C);
        if0.BUS_ENABLE = 1'b0; tick(6);

        // Level mode: single pulse while held high, bus holds after source moves on.
        if0.UNSYNC_BUS = 8'hA5; if0.BUS_ENABLE = 1'b1; push0(8'hA5, 1'b0);
        tick(5); if0.UNSYNC_BUS = 8'hFF; tick(3);
        chk("u0 hold A5", 32'(if0.SYNC_BUS), 32'hA5);
        if0.BUS_ENABLE = 1'b0; tick(4);
        if0.UNSYNC_BUS = 8'h5A; if0.BUS_ENABLE = 1'b1; push0(8'h5A, 1'b0);
        tick(6); if0.BUS_ENABLE = 1'b0;

        // Toggle mode, well-spaced events.
        tog1(8'h11); push1(8'h11, 1'b0); tick(10);
        tog1(8'h22); push1(8'h22, 1'b0); tick(10);
        tog1(8'h33); push1(8'h33, 1'b0); tick(10);

        // Gap boundary: 5 cycles apart is fine, 4 cycles apart is an overrun.
        tog1(8'h44); push1(8'h44, 1'b0); tick(5);
        tog1(8'h55); push1(8'h55, 1'b0); tick(4);
        tog1(8'h66); push1(8'h66, 1'b1); tick(8);
        chk("u1 overrun sticky", 32'(if1.OVERRUN), 1);
        if1.OVR_CLR = 1'b1; tick(1); if1.OVR_CLR = 1'b0;
        chk("u1 overrun cleared", 32'(if1.OVERRUN), 0);
        tick(6);

        // Two toggles 2 cycles apart: bus already shows C3 at the first capture.
        tog1(8'h5A); push1(8'hC3, 1'b0); tick(2);
        tog1(8'hC3); push1(8'hC3, 1'b1); tick(8);
        chk("u1 final bus C3", 32'(if1.SYNC_BUS), 32'hC3);
        chk("u1 overrun held", 32'(if1.OVERRUN), 1);
        if1.OVR_CLR = 1'b1; tick(1); if1.OVR_CLR = 1'b0;
        chk("u1 overrun cleared 2", 32'(if1.OVERRUN), 0);
        tick(6);

        // Clear coincides with a new overrun: overrun wins.
        tog1(8'h77); push1(8'h77, 1'b0); tick(2);
        tog1(8'h77); push1(8'h77, 1'b1); tick(3);
        if1.OVR_CLR = 1'b1; tick(1); if1.OVR_CLR = 1'b0;
        chk("u1 overrun beats clear", 32'(if1.OVERRUN), 1);
        tick(4);

        // Reset with an event in the chain: discarded, outputs reset at once.
        if0.UNSYNC_BUS = 8'hD2; if0.BUS_ENABLE = 1'b1; tick(1);
        RST = 1'b0; #1;
        chk("u0 async reset bus", 32'(if0.SYNC_BUS), 32'h96);
        chk("u0 async reset pulse", 32'(if0.ENABLE_PULSE), 0);
        chk("u0 async reset overrun", 32'(if0.OVERRUN), 0);
        chk("u1 async reset bus", 32'(if1.SYNC_BUS), 32'hE7);
        chk("u1 async reset overrun", 32'(if1.OVERRUN), 0);
        if0.BUS_ENABLE = 1'b0; if1.BUS_ENABLE = 1'b0;
        tick(2); RST = 1'b1; tick(10);
        chk("u0 bus after discarded event", 32'(if0.SYNC_BUS), 32'h96);
        chk("u0 pending events", q0.size(), 0);
        chk("u1 pending events", q1.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
